// File: rtl/ring_ctrl_pkg.sv
// ring_ctrl_pkg
// Shared definitions for the NetworkRing lock sequencer: the 3-bit state
// encoding reported on state_o and the default acquisition / tracking gains
// and weights.
// No ports (package).
package ring_ctrl_pkg;

    // State encoding, kept as plain constants so older code that compares
    // raw 3-bit values against state_o keeps working.
    localparam int STATE_WIDTH = 3;

    localparam logic [STATE_WIDTH-1:0] ST_IDLE    = 3'd0;
    localparam logic [STATE_WIDTH-1:0] ST_HOLD    = 3'd1;
    localparam logic [STATE_WIDTH-1:0] ST_ACQUIRE = 3'd2;
    localparam logic [STATE_WIDTH-1:0] ST_TRACK   = 3'd3;
    localparam logic [STATE_WIDTH-1:0] ST_FAIL    = 3'd4;

    // Wide-bandwidth gains used while pulling the node into lock.
    localparam logic [5:0] KP_ACQ_DEFAULT     = 6'b010010;
    localparam logic [7:0] KI_ACQ_DEFAULT     = 8'b00000100;

    // Narrow-bandwidth gains used once the node is locked.
    localparam logic [5:0] KP_TRK_DEFAULT     = 6'b001001;
    localparam logic [7:0] KI_TRK_DEFAULT     = 8'b00000001;

    // During acquisition only the left (reference) neighbour is weighted.
    localparam logic [3:0] WEIGHT_ACQ_DEFAULT = 4'd2;

endpackage

// File: rtl/edge_sync.sv
// edge_sync
// Brings an asynchronous clock-like signal into the clk_i domain through a
// 2-flop synchroniser and produces a one-cycle strobe on each rising edge.
// Ports:
//   clk_i   - destination clock
//   rst_ni  - asynchronous active-low reset, clears all flops
//   async_i - asynchronous input (e.g. a divided node clock)
//   rise_o  - one clk_i cycle pulse per rising edge of async_i
module edge_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic rise_o
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q, prev_d;

    always_comb begin
        sync1_d = async_i;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    // Decoded from flops only, so the strobe is glitch-free in clk_i.
    assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/ring_lock_sequencer.sv
// ring_lock_sequencer
// Brings one NetworkRing node out of reset, acquires lock with wide gains and
// only the reference neighbour weighted, then switches to tracking gains and
// the configured weights while watching for loss of lock.
// Ports:
//   fpga_clk_i            - system clock
//   reset_i               - asynchronous active-low reset
//   enable_i              - high requests lock, low returns to IDLE
//   gen_div8_i            - node divided clock (asynchronous), one sample per rise
//   error_i               - signed combined phase error from the node
//   weight_*_cfg_i        - neighbour weights applied while tracking
//   ring_reset_o          - active-high node reset
//   ring_enable_o         - ring oscillator enable
//   kp_o / ki_o           - node loop gains
//   weight_*_o            - node neighbour weights
//   locked_o / fail_o     - status flags (TRACK / FAIL)
//   state_o               - current state encoding
module ring_lock_sequencer
    import ring_ctrl_pkg::*;
#(
    parameter int PDET_WIDTH    = 5,
    parameter int KP_WIDTH      = 6,
    parameter int KI_WIDTH      = 8,
    parameter int WEIGHT_WIDTH  = 4,
    parameter int HOLD_CYCLES   = 64,
    parameter int LOCK_THRESH   = 2,
    parameter int LOCK_COUNT    = 16,
    parameter int UNLOCK_THRESH = 6,
    parameter int UNLOCK_COUNT  = 4,
    parameter int ACQ_TIMEOUT   = 1024,
    parameter logic [KP_WIDTH-1:0]     KP_ACQ     = KP_WIDTH'(KP_ACQ_DEFAULT),
    parameter logic [KI_WIDTH-1:0]     KI_ACQ     = KI_WIDTH'(KI_ACQ_DEFAULT),
    parameter logic [KP_WIDTH-1:0]     KP_TRK     = KP_WIDTH'(KP_TRK_DEFAULT),
    parameter logic [KI_WIDTH-1:0]     KI_TRK     = KI_WIDTH'(KI_TRK_DEFAULT),
    parameter logic [WEIGHT_WIDTH-1:0] WEIGHT_ACQ = WEIGHT_WIDTH'(WEIGHT_ACQ_DEFAULT)
) (
    input  logic                    fpga_clk_i,
    input  logic                    reset_i,
    input  logic                    enable_i,
    input  logic                    gen_div8_i,
    input  logic [PDET_WIDTH-1:0]   error_i,
    input  logic [WEIGHT_WIDTH-1:0] weight_left_cfg_i,
    input  logic [WEIGHT_WIDTH-1:0] weight_above_cfg_i,
    input  logic [WEIGHT_WIDTH-1:0] weight_right_cfg_i,
    input  logic [WEIGHT_WIDTH-1:0] weight_below_cfg_i,
    output logic                    ring_reset_o,
    output logic                    ring_enable_o,
    output logic [KP_WIDTH-1:0]     kp_o,
    output logic [KI_WIDTH-1:0]     ki_o,
    output logic [WEIGHT_WIDTH-1:0] weight_left_o,
    output logic [WEIGHT_WIDTH-1:0] weight_above_o,
    output logic [WEIGHT_WIDTH-1:0] weight_right_o,
    output logic [WEIGHT_WIDTH-1:0] weight_below_o,
    output logic                    locked_o,
    output logic                    fail_o,
    output logic [STATE_WIDTH-1:0]  state_o
);

    // Counters are sized so their terminal value is representable and they
    // can saturate there instead of wrapping.
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int BAD_W  = $clog2(UNLOCK_COUNT + 1);
    localparam int TMO_W  = $clog2(ACQ_TIMEOUT + 1);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [GOOD_W-1:0] GOOD_MAX  = GOOD_W'(LOCK_COUNT);
    localparam logic [BAD_W-1:0]  BAD_MAX   = BAD_W'(UNLOCK_COUNT);
    localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(ACQ_TIMEOUT);

    logic                   sample_stb;
    logic [PDET_WIDTH-1:0]  err_q, err_d;
    logic                   sample_valid_q, sample_valid_d;
    logic [PDET_WIDTH-1:0]  err_mag;
    logic                   is_good, is_bad;
    logic [STATE_WIDTH-1:0] state_q, state_d;
    logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
    logic [GOOD_W-1:0]      good_cnt_q, good_cnt_d;
    logic [BAD_W-1:0]       bad_cnt_q, bad_cnt_d;
    logic [TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;

    edge_sync u_gen_sync (
        .clk_i   (fpga_clk_i),
        .rst_ni  (reset_i),
        .async_i (gen_div8_i),
        .rise_o  (sample_stb)
    );

    // Capture the error on the strobe; sample_valid marks the following cycle
    // as the one where the captured value is classified.
    always_comb begin
        err_d          = sample_stb ? error_i : err_q;
        sample_valid_d = sample_stb;
    end

    // Two's-complement magnitude kept at PDET_WIDTH bits: the most negative
    // code negates to itself, which read unsigned is exactly 2^(PDET_WIDTH-1).
    always_comb begin
        err_mag = err_q[PDET_WIDTH-1] ? (~err_q + PDET_WIDTH'(1)) : err_q;
        is_good = (err_mag <= PDET_WIDTH'(LOCK_THRESH));
        is_bad  = (err_mag >  PDET_WIDTH'(UNLOCK_THRESH));
    end

    // Next-state and counter logic. Each counter is only live in its own
    // state and reads as zero elsewhere, so every entry starts from a clean
    // count. Dropping enable_i overrides everything.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = '0;
        good_cnt_d = '0;
        bad_cnt_d  = '0;
        tmo_cnt_d  = '0;

        case (state_q)
            ST_IDLE: begin
                if (enable_i) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                if (hold_cnt_q == HOLD_LAST) state_d = ST_ACQUIRE;
            end
            ST_ACQUIRE: begin
                good_cnt_d = good_cnt_q;
                tmo_cnt_d  = tmo_cnt_q;
                if (sample_valid_q) begin
                    if (!is_good)                    good_cnt_d = '0;
                    else if (good_cnt_q != GOOD_MAX) good_cnt_d = good_cnt_q + GOOD_W'(1);
                    if (tmo_cnt_q != TMO_MAX)        tmo_cnt_d  = tmo_cnt_q + TMO_W'(1);
                    // Lock beats timeout when both land on the same sample.
                    if (good_cnt_d == GOOD_MAX)      state_d = ST_TRACK;
                    else if (tmo_cnt_d == TMO_MAX)   state_d = ST_FAIL;
                end
            end
            ST_TRACK: begin
                bad_cnt_d = bad_cnt_q;
                if (sample_valid_q) begin
                    if (!is_bad)                   bad_cnt_d = '0;
                    else if (bad_cnt_q != BAD_MAX) bad_cnt_d = bad_cnt_q + BAD_W'(1);
                    if (bad_cnt_d == BAD_MAX)      state_d = ST_HOLD;
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (!enable_i) state_d = ST_IDLE;
    end

    always_ff @(posedge fpga_clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q        <= ST_IDLE;
            err_q          <= '0;
            sample_valid_q <= 1'b0;
            hold_cnt_q     <= '0;
            good_cnt_q     <= '0;
            bad_cnt_q      <= '0;
            tmo_cnt_q      <= '0;
        end else begin
            state_q        <= state_d;
            err_q          <= err_d;
            sample_valid_q <= sample_valid_d;
            hold_cnt_q     <= hold_cnt_d;
            good_cnt_q     <= good_cnt_d;
            bad_cnt_q      <= bad_cnt_d;
            tmo_cnt_q      <= tmo_cnt_d;
        end
    end

    // Outputs decode the state register only; the tracking weights are the
    // single intended pass-through from inputs.
    always_comb begin
        ring_reset_o   = 1'b1;
        ring_enable_o  = 1'b0;
        kp_o           = '0;
        ki_o           = '0;
        weight_left_o  = '0;
        weight_above_o = '0;
        weight_right_o = '0;
        weight_below_o = '0;

        case (state_q)
            ST_HOLD: begin
                ring_enable_o = 1'b1;
                kp_o          = KP_ACQ;
                ki_o          = KI_ACQ;
                weight_left_o = WEIGHT_ACQ;
            end
            ST_ACQUIRE: begin
                ring_reset_o  = 1'b0;
                ring_enable_o = 1'b1;
                kp_o          = KP_ACQ;
                ki_o          = KI_ACQ;
                weight_left_o = WEIGHT_ACQ;
            end
            ST_TRACK: begin
                ring_reset_o   = 1'b0;
                ring_enable_o  = 1'b1;
                kp_o           = KP_TRK;
                ki_o           = KI_TRK;
                weight_left_o  = weight_left_cfg_i;
                weight_above_o = weight_above_cfg_i;
                weight_right_o = weight_right_cfg_i;
                weight_below_o = weight_below_cfg_i;
            end
            default: begin
            end
        endcase
    end

    assign locked_o = (state_q == ST_TRACK);
    assign fail_o   = (state_q == ST_FAIL);
    assign state_o  = state_q;

endmodule

// File: tb/tb_ring_lock_sequencer.sv
// tb_ring_lock_sequencer
// Drives randomized phase-error samples through ring_lock_sequencer. A
// reference model predicts each state change (which state, on which cycle)
// and queues it; a monitor pops the queue whenever state_o changes and
// compares the cycle, the state and the full output bundle.
module tb_ring_lock_sequencer;

    localparam int S_IDLE = 0;
    localparam int S_HOLD = 1;
    localparam int S_ACQ  = 2;
    localparam int S_TRK  = 3;
    localparam int S_FAIL = 4;

    logic       fpga_clk_i = 1'b0;
    logic       reset_i;
    logic       enable_i;
    logic       gen_div8_i;
    logic [4:0] error_i;
    logic [3:0] cfg_l, cfg_a, cfg_r, cfg_b;
    logic       ring_reset_o, ring_enable_o, locked_o, fail_o;
    logic [5:0] kp_o;
    logic [7:0] ki_o;
    logic [3:0] weight_left_o, weight_above_o, weight_right_o, weight_below_o;
    logic [2:0] state_o;
    logic [33:0] act_out;

    ring_lock_sequencer dut (
        .fpga_clk_i         (fpga_clk_i),
        .reset_i            (reset_i),
        .enable_i           (enable_i),
        .gen_div8_i         (gen_div8_i),
        .error_i            (error_i),
        .weight_left_cfg_i  (cfg_l),
        .weight_above_cfg_i (cfg_a),
        .weight_right_cfg_i (cfg_r),
        .weight_below_cfg_i (cfg_b),
        .ring_reset_o       (ring_reset_o),
        .ring_enable_o      (ring_enable_o),
        .kp_o               (kp_o),
        .ki_o               (ki_o),
        .weight_left_o      (weight_left_o),
        .weight_above_o     (weight_above_o),
        .weight_right_o     (weight_right_o),
        .weight_below_o     (weight_below_o),
        .locked_o           (locked_o),
        .fail_o             (fail_o),
        .state_o            (state_o)
    );

    assign act_out = {ring_reset_o, ring_enable_o, kp_o, ki_o, weight_left_o,
                      weight_above_o, weight_right_o, weight_below_o, locked_o, fail_o};

    // Free-running clock and a cycle index bumped on each rising edge.
    always #5 fpga_clk_i = ~fpga_clk_i;

    int cyc = 0;
    always @(posedge fpga_clk_i) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int cyc;
        int st;
    } ev_t;

    ev_t exp_q[$];

    int mon_state = S_IDLE;
    int m_mode    = S_IDLE;
    int m_good    = 0;
    int m_bad     = 0;
    int m_tmo     = 0;
    int m_hold_end = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    // Expected output bundle for a given state, straight from the state table.
    function automatic logic [33:0] expOutputs(input int st);
        logic       rr, re, lk, fl;
        logic [5:0] kp;
        logic [7:0] ki;
        logic [3:0] wl, wa, wr, wb;
        rr = 1'b1; re = 1'b0; kp = 6'd0; ki = 8'd0;
        wl = 4'd0; wa = 4'd0; wr = 4'd0; wb = 4'd0;
        lk = (st == S_TRK);
        fl = (st == S_FAIL);
        if (st == S_HOLD || st == S_ACQ) begin
            rr = (st == S_HOLD);
            re = 1'b1; kp = 6'b010010; ki = 8'b00000100; wl = 4'd2;
        end else if (st == S_TRK) begin
            rr = 1'b0; re = 1'b1; kp = 6'b001001; ki = 8'b00000001;
            wl = cfg_l; wa = cfg_a; wr = cfg_r; wb = cfg_b;
        end
        return {rr, re, kp, ki, wl, wa, wr, wb, lk, fl};
    endfunction

    function automatic void pushEv(input int c, input int s);
        ev_t e;
        e.cyc = c;
        e.st  = s;
        exp_q.push_back(e);
    endfunction

    // Model: a state change to IDLE effective at cycle t cancels anything
    // predicted from t onwards.
    function automatic void modelGoIdle(input int t);
        int prev;
        while (exp_q.size() > 0 && exp_q[$].cyc >= t) void'(exp_q.pop_back());
        prev = (exp_q.size() > 0) ? exp_q[$].st : mon_state;
        if (prev != S_IDLE) pushEv(t, S_IDLE);
        m_mode = S_IDLE;
    endfunction

    // Model: enable seen after the edge of cycle c.
    function automatic void modelEnable(input int c);
        if (m_mode == S_IDLE) begin
            pushEv(c + 1, S_HOLD);
            pushEv(c + 65, S_ACQ);
            m_mode     = S_HOLD;
            m_hold_end = c + 65;
        end
    endfunction

    // Model: a sample launched after the edge of cycle c takes effect on the
    // edge of cycle c+4.
    function automatic void modelSample(input int err, input int c);
        int t, mag;
        t   = c + 4;
        mag = (err < 0) ? -err : err;
        if (m_mode == S_HOLD && t > m_hold_end) begin
            m_mode = S_ACQ;
            m_good = 0;
            m_tmo  = 0;
        end
        if (m_mode == S_ACQ) begin
            m_good = (mag <= 2) ? ((m_good < 16) ? m_good + 1 : 16) : 0;
            m_tmo  = (m_tmo < 1024) ? m_tmo + 1 : 1024;
            if (m_good == 16) begin
                pushEv(t, S_TRK);
                m_mode = S_TRK;
                m_bad  = 0;
            end else if (m_tmo == 1024) begin
                pushEv(t, S_FAIL);
                m_mode = S_FAIL;
            end
        end else if (m_mode == S_TRK) begin
            m_bad = (mag > 6) ? ((m_bad < 4) ? m_bad + 1 : 4) : 0;
            if (m_bad == 4) begin
                pushEv(t, S_HOLD);
                pushEv(t + 64, S_ACQ);
                m_mode     = S_HOLD;
                m_hold_end = t + 64;
            end
        end
    endfunction

    function automatic int randGood();
        return int'($urandom_range(0, 4)) - 2;
    endfunction

    function automatic int randMid();
        int mag;
        mag = int'($urandom_range(3, 6));
        return ($urandom_range(0, 1) == 1) ? mag : -mag;
    endfunction

    function automatic int randBad();
        int mag;
        mag = int'($urandom_range(7, 16));
        if (mag == 16 || $urandom_range(0, 1) == 1) return -mag;
        return mag;
    endfunction

    // Monitor: every change of state_o is a DUT "response" matched against
    // the next predicted event.
    always @(negedge fpga_clk_i) begin : monitor
        ev_t e;
        if (int'(state_o) != mon_state) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL unexpected_transition at cycle %0d: actual state=%0d required state=%0d",
                         cyc, state_o, mon_state);
            end else begin
                e = exp_q.pop_front();
                checkOutput("event_cycle", 64'(cyc), 64'(e.cyc));
                checkOutput("event_state", 64'(state_o), 64'(e.st));
                checkOutput("event_outputs", 64'(act_out), 64'(expOutputs(e.st)));
            end
            mon_state = int'(state_o);
        end
    end

    // One node sample: raise gen_div8_i with the error held for 8+ cycles.
    task automatic applyStimulus(input int err);
        @(posedge fpga_clk_i);
        #1;
        error_i    = 5'(err);
        gen_div8_i = 1'b1;
        modelSample(err, cyc);
        repeat (4) @(posedge fpga_clk_i);
        #1;
        gen_div8_i = 1'b0;
        repeat (3 + $urandom_range(0, 2)) @(posedge fpga_clk_i);
    endtask

    task automatic enableOn();
        @(posedge fpga_clk_i);
        #1;
        enable_i = 1'b1;
        modelEnable(cyc);
    endtask

    task automatic enableOff();
        @(posedge fpga_clk_i);
        #1;
        enable_i = 1'b0;
        modelGoIdle(cyc + 1);
    endtask

    task automatic restartToAcquire();
        enableOff();
        repeat (2) @(posedge fpga_clk_i);
        enableOn();
        repeat (66) @(posedge fpga_clk_i);
    endtask

    initial begin
        int r;
        reset_i    = 1'b0;
        enable_i   = 1'b0;
        gen_div8_i = 1'b0;
        error_i    = 5'd0;
        cfg_l      = 4'($urandom);
        cfg_a      = 4'($urandom);
        cfg_r      = 4'($urandom);
        cfg_b      = 4'($urandom);

        repeat (3) @(posedge fpga_clk_i);
        #1;
        checkOutput("reset_outputs", 64'(act_out), 64'(expOutputs(S_IDLE)));
        checkOutput("reset_state", 64'(state_o), 64'(S_IDLE));
        @(posedge fpga_clk_i);
        #1;
        reset_i = 1'b1;
        repeat (2) @(posedge fpga_clk_i);

        $display("[TB] enable, hold and acquire");
        enableOn();
        repeat (66) @(posedge fpga_clk_i);

        $display("[TB] sixteen good samples to lock");
        repeat (16) applyStimulus(randGood());
        @(posedge fpga_clk_i);
        #1;
        cfg_a = cfg_a ^ 4'hF;
        #1;
        checkOutput("weight_follow", 64'(weight_above_o), 64'(cfg_a));
        cfg_a = cfg_a ^ 4'hF;

        $display("[TB] short bad burst then unlock");
        repeat (3) applyStimulus(-16);
        applyStimulus(0);
        repeat (4) applyStimulus(randBad());
        repeat (66) @(posedge fpga_clk_i);

        $display("[TB] broken good run");
        repeat (15) applyStimulus(randGood());
        applyStimulus(-3);
        repeat (16) applyStimulus(randGood());

        $display("[TB] random mix");
        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 7)      applyStimulus(randGood());
            else if (r < 9) applyStimulus(randMid());
            else            applyStimulus(randBad());
        end
        restartToAcquire();

        $display("[TB] acquisition timeout");
        repeat (1024) applyStimulus(randMid());
        restartToAcquire();

        $display("[TB] lock and timeout on the same sample");
        repeat (1008) applyStimulus(randMid());
        repeat (16) applyStimulus(randGood());
        restartToAcquire();

        $display("[TB] enable dropped on the locking sample");
        repeat (15) applyStimulus(randGood());
        @(posedge fpga_clk_i);
        #1;
        r          = randGood();
        error_i    = 5'(r);
        gen_div8_i = 1'b1;
        modelSample(r, cyc);
        repeat (3) @(posedge fpga_clk_i);
        #1;
        enable_i = 1'b0;
        modelGoIdle(cyc + 1);
        @(posedge fpga_clk_i);
        #1;
        gen_div8_i = 1'b0;
        repeat (5) @(posedge fpga_clk_i);
        enableOn();
        repeat (66) @(posedge fpga_clk_i);

        $display("[TB] asynchronous reset during acquire");
        repeat (5) applyStimulus(randGood());
        @(posedge fpga_clk_i);
        #3;
        reset_i = 1'b0;
        modelGoIdle(cyc);
        #1;
        checkOutput("async_reset_outputs", 64'(act_out), 64'(expOutputs(S_IDLE)));
        checkOutput("async_reset_state", 64'(state_o), 64'(S_IDLE));
        repeat (3) @(posedge fpga_clk_i);
        #1;
        reset_i = 1'b1;
        modelEnable(cyc);
        repeat (70) @(posedge fpga_clk_i);

        checkOutput("pending_events", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
